// File: rtl/qr4_pkg.sv
// Shared helpers for the inverse ChaCha quarter-round block: rotates, the forward
// quarter round, the controller state encoding and the per-round step count.
package qr4_pkg;

  localparam int unsigned QR_STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } qr_state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } qr_words_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic qr_words_t qr_fwd(input qr_words_t w);
    qr_words_t r;
    r   = w;
    r.a = r.a + r.b;  r.d = rotl(r.d ^ r.a, 16);
    r.c = r.c + r.d;  r.b = rotl(r.b ^ r.c, 12);
    r.a = r.a + r.b;  r.d = rotl(r.d ^ r.a, 8);
    r.c = r.c + r.d;  r.b = rotl(r.b ^ r.c, 7);
    return r;
  endfunction

endpackage

// File: rtl/qr4_inv_step.sv
// One quarter of an inverse ChaCha quarter round, selected by step_i.
// Purely combinational; each step undoes one add/xor/rotate pair of the forward round, last pair first.
module qr4_inv_step
  import qr4_pkg::*;
(
  input  logic [1:0]  step_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    d_o = d_i;
    case (step_i)
      2'd0: begin
        b_o = rotr(b_i, 7) ^ c_i;
        c_o = c_i - d_i;
      end
      2'd1: begin
        d_o = rotr(d_i, 8) ^ a_i;
        a_o = a_i - b_i;
      end
      2'd2: begin
        b_o = rotr(b_i, 12) ^ c_i;
        c_o = c_i - d_i;
      end
      default: begin
        d_o = rotr(d_i, 16) ^ a_i;
        a_o = a_i - b_i;
      end
    endcase
  end

endmodule

// File: rtl/qr4_inv.sv
// Iterative inverse ChaCha quarter round: N_QR rounds of four single-cycle steps, valid/ready at both ends.
// Optional QR4_INV_SELFCHECK_EN adds chk_err, re-running the forward round on the result in DONE.
module qr4_inv
  import qr4_pkg::*;
#(
  parameter int unsigned N_QR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic        busy
`ifdef QR4_INV_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);

  localparam logic [7:0] LAST_RND  = 8'(N_QR - 1);
  localparam logic [1:0] LAST_STEP = 2'(QR_STEPS - 1);

  qr_state_t  state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [7:0] rnd_q, rnd_d;
  qr_words_t  w_q, w_d, step_w;
  logic       last_step;

  assign last_step = (step_q == LAST_STEP) && (rnd_q == LAST_RND);

  qr4_inv_step u_step (
    .step_i (step_q),
    .a_i    (w_q.a),
    .b_i    (w_q.b),
    .c_i    (w_q.c),
    .d_i    (w_q.d),
    .a_o    (step_w.a),
    .b_o    (step_w.b),
    .c_o    (step_w.c),
    .d_o    (step_w.d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Step counter wraps 3 -> 0 and carries into the round counter.
  always_comb begin
    w_d    = w_q;
    step_d = step_q;
    rnd_d  = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d    = '{a: a_in, b: b_in, c: c_in, d: d_in};
          step_d = 2'd0;
          rnd_d  = 8'd0;
        end
      end
      RUN: begin
        w_d    = step_w;
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) rnd_d = rnd_q + 8'd1;
      end
      default: begin
        step_d = 2'd0;
        rnd_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      step_q <= 2'd0;
      rnd_q  <= 8'd0;
    end else begin
      w_q    <= w_d;
      step_q <= step_d;
      rnd_q  <= rnd_d;
    end
  end

  assign a_out = w_q.a;
  assign b_out = w_q.b;
  assign c_out = w_q.c;
  assign d_out = w_q.d;

`ifdef QR4_INV_SELFCHECK_EN
  qr_words_t snap_q;

  // The forward round of the final result must land back on the start-of-final-round state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (state_q == RUN && step_q == 2'd0 && rnd_q == LAST_RND) begin
      snap_q <= w_q;
    end
  end

  assign chk_err = (state_q == DONE) && (qr_fwd(w_q) != snap_q);
`endif

endmodule
